// File: rtl/uart_tx_cts.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cts
// Description : UART transmitter (8-N-1 / 8-N-2) with hardware CTS flow
//               control. Bytes arrive on a valid/ready sink. A new frame is
//               started only while the synchronised peer CTS is asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cts #(
  parameter int unsigned CLKS_PER_BIT = 218,  // clk_i cycles per bit, 2..65535
  parameter int unsigned STOP_BITS    = 1     // 1 or 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  input  logic       cts_n_i,
  output logic       tx_serial_o,
  output logic       busy_o
);

  localparam int unsigned        BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // Index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic               STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic              stop_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              cts_meta_q;
  logic              cts_sync_q;

  logic cts_ok;
  logic bit_end;

  assign cts_ok      = ~cts_sync_q;
  assign bit_end     = (baud_q == BAUD_LAST);
  assign ready_o     = (state_q == S_IDLE) & cts_ok;
  assign busy_o      = (state_q != S_IDLE);
  assign tx_serial_o = tx_q;

  // Two-flop synchroniser for the asynchronous peer CTS; resets to deasserted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n_i;
      cts_sync_q <= cts_meta_q;
    end
  end

  // Frame FSM: drives the registered serial line, baud and bit counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (valid_i && ready_o) begin
            shift_q <= data_i;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= 3'd0;
              tx_q      <= 1'b1;
              state_q   <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (stop_idx_q == STOP_LAST) begin
              stop_idx_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              stop_idx_q <= ~stop_idx_q;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cts.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cts
// Description : Directed self-checking bench for uart_tx_cts with
//               CLKS_PER_BIT=4, one instance per stop-bit setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cts;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cts_n;
  logic       valid1, valid2;
  logic [7:0] data1, data2;
  logic       ready1, tx1, busy1;
  logic       ready2, tx2, busy2;

  int checks   = 0;
  int failures = 0;
  int hs1      = 0;
  int hs2      = 0;

  uart_tx_cts #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk_i(clk), .reset_i(rst), .valid_i(valid1), .ready_o(ready1),
    .data_i(data1), .cts_n_i(cts_n), .tx_serial_o(tx1), .busy_o(busy1)
  );

  uart_tx_cts #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk_i(clk), .reset_i(rst), .valid_i(valid2), .ready_o(ready2),
    .data_i(data2), .cts_n_i(cts_n), .tx_serial_o(tx2), .busy_o(busy2)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (valid1 === 1'b1 && ready1 === 1'b1) hs1++;
    if (valid2 === 1'b1 && ready2 === 1'b1) hs2++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int w);
    return (w == 2) ? ready2 : ready1;
  endfunction

  function automatic logic tx_of(input int w);
    return (w == 2) ? tx2 : tx1;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 2) ? busy2 : busy1;
  endfunction

  // Waits (bounded) for ready, presents one byte, returns at the sample just after the handshake edge.
  task automatic send(input int w, input logic [7:0] d, input bit keep);
    int n = 0;
    while (rdy_of(w) !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk($sformatf("ready_before_send_%0h", d), {31'd0, rdy_of(w)}, 32'd1);
    if (w == 2) begin valid2 = 1'b1; data2 = d; end
    else        begin valid1 = 1'b1; data1 = d; end
    step();
    if (!keep) begin
      if (w == 2) valid2 = 1'b0;
      else        valid1 = 1'b0;
    end
  endtask

  // Samples every cycle of a frame starting at the current sample point (first start-bit cycle).
  task automatic check_frame(input string tag, input int w, input logic [7:0] d,
                             input int nstop, input int cts_bit);
    int   busy_cnt = 0;
    logic eb;
    for (int b = 0; b < 9 + nstop; b++) begin
      logic [CPB-1:0] s;
      if (b == 0)      eb = 1'b0;
      else if (b <= 8) eb = d[b-1];
      else             eb = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (b == cts_bit && c == 1) cts_n = 1'b1;
        s[c] = tx_of(w);
        if (busy_of(w) === 1'b1) busy_cnt++;
        step();
      end
      chk($sformatf("%s_bit%0d", tag, b), {28'd0, s}, {28'd0, {CPB{eb}}});
    end
    chk($sformatf("%s_busy_cycles", tag), busy_cnt, (9 + nstop) * CPB);
    chk($sformatf("%s_idle_after", tag), {30'd0, busy_of(w), tx_of(w)}, 32'd1);
  endtask

  initial begin
    int hs0;
    int bad;
    int n;

    rst    = 1'b1;
    cts_n  = 1'b0;
    valid1 = 1'b0;
    valid2 = 1'b0;
    data1  = 8'h00;
    data2  = 8'h00;

    // Reset state and CTS synchroniser latency.
    step(); step(); step();
    chk("reset_state1", {29'd0, tx1, busy1, ready1}, 32'b100);
    chk("reset_state2", {29'd0, tx2, busy2, ready2}, 32'b100);
    rst = 1'b0;
    chk("ready_at_release", {31'd0, ready1}, 32'd0);
    step();
    chk("ready_edge1", {31'd0, ready1}, 32'd0);
    step();
    chk("ready_edge2", {31'd0, ready1}, 32'd1);

    // Single byte 0xA5.
    hs0 = hs1;
    send(1, 8'hA5, 1'b0);
    check_frame("a5", 1, 8'hA5, 1, -1);
    chk("a5_handshakes", hs1 - hs0, 1);

    // Back-to-back 0x00 then 0xFF with valid held high.
    hs0 = hs1;
    send(1, 8'h00, 1'b1);
    data1 = 8'hFF;
    check_frame("b2b0", 1, 8'h00, 1, -1);
    step();
    valid1 = 1'b0;
    check_frame("b2b1", 1, 8'hFF, 1, -1);
    chk("b2b_handshakes", hs1 - hs0, 2);

    // CTS deasserted with valid high: nothing sent; release -> handshake within 3 edges.
    cts_n = 1'b1;
    step(); step(); step();
    chk("cts_off_ready", {31'd0, ready1}, 32'd0);
    valid1 = 1'b1;
    data1  = 8'h5A;
    hs0    = hs1;
    bad    = 0;
    for (int i = 0; i < 100; i++) begin
      if (ready1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
      step();
    end
    chk("cts_off_quiet", bad, 0);
    chk("cts_off_no_hs", hs1 - hs0, 0);
    cts_n = 1'b0;
    n = 0;
    while (busy1 !== 1'b1 && n < 6) begin
      step();
      n++;
    end
    valid1 = 1'b0;
    chk("cts_on_latency_le3", {31'd0, (n >= 1 && n <= 3)}, 32'd1);
    check_frame("5a", 1, 8'h5A, 1, -1);

    // CTS rises during data bit 3 of 0x3C: frame completes, then no handshake.
    send(1, 8'h3C, 1'b0);
    check_frame("3c", 1, 8'h3C, 1, 4);
    valid1 = 1'b1;
    data1  = 8'h77;
    hs0    = hs1;
    bad    = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b0) bad++;
      step();
    end
    valid1 = 1'b0;
    chk("cts_mid_quiet", bad, 0);
    chk("cts_mid_no_hs", hs1 - hs0, 0);
    cts_n = 1'b0;

    // Reset mid-frame during bit 5, then 0x81 bit-exact.
    send(1, 8'hC3, 1'b0);
    for (int i = 0; i < CPB * 6 + 1; i++) step();
    chk("pre_reset_bit5", {30'd0, busy1, tx1}, {30'd0, 1'b1, 1'b0});
    #3;
    rst = 1'b1;
    #1;
    chk("reset_async", {29'd0, tx1, busy1, ready1}, 32'b100);
    step();
    rst = 1'b0;
    hs0 = hs1;
    send(1, 8'h81, 1'b0);
    check_frame("81", 1, 8'h81, 1, -1);
    chk("81_handshakes", hs1 - hs0, 1);

    // Two stop bits: 0xA5 frame of 44 cycles.
    hs0 = hs2;
    send(2, 8'hA5, 1'b0);
    check_frame("a5s2", 2, 8'hA5, 2, -1);
    chk("a5s2_handshakes", hs2 - hs0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
